lsu_ctrl: RTL and testbench

Load/store control unit between the execute stage and `data_memory`. It accepts one memory request per handshake, forms the effective word address (base register + sign-extended offset), range-checks it against the 64-word data memory, and then drives the memory port. A store is a single-cycle write. A load captures the combinational read data. Each request returns one response pulse to the register write-back path.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_addr_gen.sv | 27 ++
 rtl/lsu_ctrl.sv | 150 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control unit.
// Imported by the FSM top and the address generator.
package lsu_pkg;

    localparam int LSU_ADDR_W = 6;
    localparam int LSU_DATA_W = 64;
    localparam int LSU_OFF_W  = 16;
    localparam int LSU_RD_W   = 5;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_CALC,
        LSU_ACCESS,
        LSU_RESP
    } lsu_state_e;

    typedef struct packed {
        logic                  is_store;
        logic [LSU_DATA_W-1:0] base;
        logic [LSU_OFF_W-1:0]  offset;
        logic [LSU_DATA_W-1:0] store_data;
        logic [LSU_RD_W-1:0]   rd;
    } lsu_req_t;

endpackage

// File: rtl/lsu_addr_gen.sv
// Effective address generator: base + sign-extended offset.
// Flags any address that falls outside the word-addressed memory.
module lsu_addr_gen
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int OFF_W  = LSU_OFF_W
) (
    input  logic [DATA_W-1:0] base,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] addr,
    output logic              out_of_range
);

    logic [DATA_W-1:0] off_sext;
    logic [DATA_W-1:0] eff;

    // Sign-extend, add modulo 2^DATA_W, and check the upper bits.
    always_comb begin
        off_sext     = {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};
        eff          = base + off_sext;
        addr         = eff[ADDR_W-1:0];
        out_of_range = |eff[DATA_W-1:ADDR_W];
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control FSM: accept, address calc, memory access, response.
// One request in flight; all outputs are registered.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W,
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int OFF_W  = LSU_OFF_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [DATA_W-1:0] req_base,
    input  logic [OFF_W-1:0]  req_offset,
    input  logic [DATA_W-1:0] req_store_data,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] d_mem_addr,
    output logic              d_mem_we,
    output logic [DATA_W-1:0] d_mem_data_in,
    input  logic [DATA_W-1:0] d_mem_data_out,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_is_store,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  cnt_load,
    output logic [CNT_W-1:0]  cnt_store,
    output logic [CNT_W-1:0]  cnt_err
);

    lsu_state_e        state_q;
    lsu_req_t          req_q;
    logic [ADDR_W-1:0] eff_q;
    logic              ready_q;
    logic              we_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [4:0]        rsp_rd_q;
    logic              rsp_is_store_q;
    logic              rsp_err_q;
    logic [CNT_W-1:0]  cnt_load_q;
    logic [CNT_W-1:0]  cnt_store_q;
    logic [CNT_W-1:0]  cnt_err_q;

    logic [ADDR_W-1:0] ag_addr;
    logic              ag_oor;

    lsu_addr_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_addr_gen (
        .base         (req_q.base),
        .offset       (req_q.offset),
        .addr         (ag_addr),
        .out_of_range (ag_oor)
    );

    // Request FSM with registered memory-port, response and counter outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= LSU_IDLE;
            req_q          <= '0;
            eff_q          <= '0;
            ready_q        <= 1'b1;
            we_q           <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_rd_q       <= '0;
            rsp_is_store_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            cnt_load_q     <= '0;
            cnt_store_q    <= '0;
            cnt_err_q      <= '0;
        end else begin
            unique case (state_q)
                LSU_IDLE: begin
                    if (req_valid) begin
                        req_q.is_store   <= req_is_store;
                        req_q.base       <= req_base;
                        req_q.offset     <= req_offset;
                        req_q.store_data <= req_store_data;
                        req_q.rd         <= req_rd;
                        ready_q          <= 1'b0;
                        state_q          <= LSU_CALC;
                    end
                end
                LSU_CALC: begin
                    eff_q          <= ag_addr;
                    rsp_rd_q       <= req_q.rd;
                    rsp_is_store_q <= req_q.is_store;
                    if (ag_oor) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= LSU_RESP;
                    end else begin
                        we_q    <= req_q.is_store;
                        state_q <= LSU_ACCESS;
                    end
                end
                LSU_ACCESS: begin
                    we_q        <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= req_q.is_store ? '0 : d_mem_data_out;
                    state_q     <= LSU_RESP;
                end
                LSU_RESP: begin
                    if (rsp_err_q) begin
                        if (cnt_err_q != '1)
                            cnt_err_q <= cnt_err_q + 1'b1;
                    end else if (rsp_is_store_q) begin
                        if (cnt_store_q != '1)
                            cnt_store_q <= cnt_store_q + 1'b1;
                    end else begin
                        if (cnt_load_q != '1)
                            cnt_load_q <= cnt_load_q + 1'b1;
                    end
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= LSU_IDLE;
                end
                default: begin
                    we_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= LSU_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = ready_q;
    assign d_mem_addr    = eff_q;
    assign d_mem_we      = we_q;
    assign d_mem_data_in = req_q.store_data;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_rd        = rsp_rd_q;
    assign rsp_is_store  = rsp_is_store_q;
    assign rsp_err       = rsp_err_q;
    assign cnt_load      = cnt_load_q;
    assign cnt_store     = cnt_store_q;
    assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a behavioural 64-word memory.
// Cycle k is the interval after edge k; sampling is 1ns after each edge.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [63:0] req_base;
    logic [15:0] req_offset;
    logic [63:0] req_store_data;
    logic [4:0]  req_rd;
    logic [5:0]  d_mem_addr;
    logic        d_mem_we;
    logic [63:0] d_mem_data_in;
    logic [63:0] d_mem_data_out;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_is_store;
    logic        rsp_err;
    logic [15:0] cnt_load;
    logic [15:0] cnt_store;
    logic [15:0] cnt_err;

    logic [63:0] mem [64];

    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (d_mem_we === 1'b1)
            mem[d_mem_addr] <= d_mem_data_in;
    end

    assign d_mem_data_out = mem[d_mem_addr];

    lsu_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_base       (req_base),
        .req_offset     (req_offset),
        .req_store_data (req_store_data),
        .req_rd         (req_rd),
        .d_mem_addr     (d_mem_addr),
        .d_mem_we       (d_mem_we),
        .d_mem_data_in  (d_mem_data_in),
        .d_mem_data_out (d_mem_data_out),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_rd         (rsp_rd),
        .rsp_is_store   (rsp_is_store),
        .rsp_err        (rsp_err),
        .cnt_load       (cnt_load),
        .cnt_store      (cnt_store),
        .cnt_err        (cnt_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in an IDLE cycle; returns in cycle 1 (CALC).
    task automatic issue(input logic st, input logic [63:0] base,
                         input logic [15:0] off, input logic [63:0] data,
                         input logic [4:0] rd);
        req_is_store   = st;
        req_base       = base;
        req_offset     = off;
        req_store_data = data;
        req_rd         = rd;
        req_valid      = 1'b1;
        cyc();
        req_valid      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 64'h0;
        mem[1] = 64'd10;
        mem[2] = 64'd30;
        rst_n          = 1'b0;
        req_valid      = 1'b1;
        req_is_store   = 1'b1;
        req_base       = 64'd9;
        req_offset     = 16'd0;
        req_store_data = 64'hDEAD;
        req_rd         = 5'd1;
        cyc();
        cyc();

        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_is_store", rsp_is_store, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_rd", rsp_rd, 0);
        chk("rst_we", d_mem_we, 0);
        chk("rst_addr", d_mem_addr, 0);
        chk("rst_data_in", d_mem_data_in, 0);
        chk("rst_cnt_load", cnt_load, 0);
        chk("rst_cnt_store", cnt_store, 0);
        chk("rst_cnt_err", cnt_err, 0);

        req_valid = 1'b0;
        rst_n     = 1'b1;
        cyc();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_mem9", mem[9], 0);

        // Load mem[1]
        issue(1'b0, 64'd0, 16'd1, 64'd0, 5'd3);
        chk("ld1_c1_ready", req_ready, 0);
        chk("ld1_c1_valid", rsp_valid, 0);
        cyc();
        chk("ld1_c2_addr", d_mem_addr, 1);
        chk("ld1_c2_we", d_mem_we, 0);
        chk("ld1_c2_valid", rsp_valid, 0);
        cyc();
        chk("ld1_c3_valid", rsp_valid, 1);
        chk("ld1_c3_data", rsp_data, 10);
        chk("ld1_c3_rd", rsp_rd, 3);
        chk("ld1_c3_err", rsp_err, 0);
        chk("ld1_c3_is_store", rsp_is_store, 0);
        chk("ld1_c3_ready", req_ready, 0);
        cyc();
        chk("ld1_c4_valid", rsp_valid, 0);
        chk("ld1_c4_ready", req_ready, 1);
        chk("ld1_cnt_load", cnt_load, 1);

        // Store 0x55 to 2+3
        issue(1'b1, 64'd2, 16'd3, 64'h55, 5'd7);
        chk("st_c1_we", d_mem_we, 0);
        cyc();
        chk("st_c2_we", d_mem_we, 1);
        chk("st_c2_addr", d_mem_addr, 5);
        chk("st_c2_data_in", d_mem_data_in, 64'h55);
        cyc();
        chk("st_c3_we", d_mem_we, 0);
        chk("st_c3_valid", rsp_valid, 1);
        chk("st_c3_is_store", rsp_is_store, 1);
        chk("st_c3_data", rsp_data, 0);
        chk("st_c3_rd", rsp_rd, 7);
        cyc();
        chk("st_cnt_store", cnt_store, 1);
        chk("st_mem5", mem[5], 64'h55);
        chk("st_c4_data_in_held", d_mem_data_in, 64'h55);
        chk("st_c4_addr_held", d_mem_addr, 5);

        // Load back from 5
        issue(1'b0, 64'd5, 16'd0, 64'd0, 5'd4);
        cyc();
        cyc();
        chk("ld5_valid", rsp_valid, 1);
        chk("ld5_data", rsp_data, 64'h55);
        cyc();

        // Negative offset: 3 + (-1)
        issue(1'b0, 64'd3, 16'hFFFF, 64'd0, 5'd6);
        cyc();
        chk("neg_addr", d_mem_addr, 2);
        cyc();
        chk("neg_valid", rsp_valid, 1);
        chk("neg_data", rsp_data, 30);
        cyc();

        // Out of range: 60 + 4 = 64
        issue(1'b1, 64'd60, 16'd4, 64'h77, 5'd8);
        chk("oor1_c1_we", d_mem_we, 0);
        chk("oor1_c1_valid", rsp_valid, 0);
        cyc();
        chk("oor1_c2_valid", rsp_valid, 1);
        chk("oor1_c2_err", rsp_err, 1);
        chk("oor1_c2_data", rsp_data, 0);
        chk("oor1_c2_we", d_mem_we, 0);
        chk("oor1_c2_rd", rsp_rd, 8);
        cyc();
        chk("oor1_c3_valid", rsp_valid, 0);
        chk("oor1_c3_ready", req_ready, 1);
        chk("oor1_c3_we", d_mem_we, 0);
        chk("oor1_cnt_err", cnt_err, 1);
        chk("oor1_cnt_store", cnt_store, 1);

        // Out of range: 0 + (-1) wraps to all-ones
        issue(1'b0, 64'd0, 16'hFFFF, 64'd0, 5'd9);
        chk("oor2_c1_we", d_mem_we, 0);
        cyc();
        chk("oor2_c2_valid", rsp_valid, 1);
        chk("oor2_c2_err", rsp_err, 1);
        chk("oor2_c2_data", rsp_data, 0);
        chk("oor2_c2_we", d_mem_we, 0);
        cyc();
        chk("oor2_cnt_err", cnt_err, 2);
        chk("oor2_cnt_load", cnt_load, 3);

        // Three back-to-back loads with req_valid held high
        issue(1'b0, 64'd1, 16'd0, 64'd0, 5'd9);
        req_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c == 9) req_valid = 1'b0;
            chk($sformatf("b2b_valid_c%0d", c), rsp_valid,
                (c == 3 || c == 7 || c == 11) ? 1 : 0);
            chk($sformatf("b2b_ready_c%0d", c), req_ready,
                (c == 4 || c == 8) ? 1 : 0);
            if (c == 3 || c == 7 || c == 11) begin
                chk($sformatf("b2b_data_c%0d", c), rsp_data, 10);
                chk($sformatf("b2b_rd_c%0d", c), rsp_rd, 9);
            end
            cyc();
        end
        chk("b2b_c12_ready", req_ready, 1);
        chk("b2b_c12_valid", rsp_valid, 0);
        chk("b2b_cnt_load", cnt_load, 6);

        // Reset sampled during ACCESS of a store to addr 7
        issue(1'b1, 64'd7, 16'd0, 64'hAB, 5'd2);
        cyc();
        chk("rstacc_c2_we", d_mem_we, 1);
        rst_n = 1'b0;
        cyc();
        chk("rstacc_mem7", mem[7], 64'hAB);
        chk("rstacc_ready", req_ready, 1);
        chk("rstacc_valid", rsp_valid, 0);
        chk("rstacc_we", d_mem_we, 0);
        chk("rstacc_cnt_load", cnt_load, 0);
        chk("rstacc_cnt_store", cnt_store, 0);
        chk("rstacc_cnt_err", cnt_err, 0);
        rst_n = 1'b1;
        mem[7] = 64'h0;
        cyc();
        chk("rstacc_c4_valid", rsp_valid, 0);
        chk("rstacc_c4_we", d_mem_we, 0);
        cyc();
        chk("rstacc_c5_valid", rsp_valid, 0);
        chk("rstacc_c5_mem7", mem[7], 0);
        chk("rstacc_c5_ready", req_ready, 1);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
